sdram_bist: RTL

- Built-in self-test sequencer that sits directly upstream of the sdram controller and drives its rd/wr/refresh/addr/din command port.
- Writes an LFSR byte pattern to every address in the range, then reads every address back and compares.
- Reports done/pass/fail plus a saturating error count, for the board LEDs and debug.

---
 rtl/sdram_bist_if.sv | 23 ++
 rtl/sdram_bist.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_bist_if.sv
// Command/response bus between the BIST sequencer (master) and the sdram controller (slave).
interface sdram_bist_if #(
    parameter int unsigned ADDR_W = 26
);
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_refresh;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic              mem_busy;
    logic              mem_data_ready;

    modport master (
        output mem_rd, mem_wr, mem_refresh, mem_addr, mem_din,
        input  mem_dout, mem_busy, mem_data_ready
    );

    modport slave (
        input  mem_rd, mem_wr, mem_refresh, mem_addr, mem_din,
        output mem_dout, mem_busy, mem_data_ready
    );
endinterface

// File: rtl/sdram_bist.sv
// SDRAM built-in self-test: writes an LFSR byte pattern over the whole address range, reads it back and counts errors.
// Optional first-error capture outputs are enabled by defining SDRAM_BIST_ERR_CAPTURE_EN.
module sdram_bist #(
    parameter int unsigned ADDR_W         = 26,
    parameter logic [7:0]  SEED           = 8'hA5,
    parameter int unsigned REFRESH_PERIOD = 512,
    parameter int unsigned TIMEOUT        = 64
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    sdram_bist_if.master       mem,
    output logic               running,
    output logic               phase,
    output logic               done,
    output logic               pass,
    output logic               fail,
    output logic [15:0]        err_count
`ifdef SDRAM_BIST_ERR_CAPTURE_EN
    ,
    output logic [ADDR_W-1:0]  first_err_addr,
    output logic [7:0]         first_err_exp,
    output logic [7:0]         first_err_got,
    output logic               first_err_valid
`endif
);

    localparam int unsigned RCNT_W = $clog2(REFRESH_PERIOD + 1);
    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_WAIT,
        RD_ISSUE,
        RD_WAIT,
        REFRESH,
        DONE
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   addr, addr_n;
    logic [7:0]          lfsr, lfsr_n;
    logic [15:0]         err_n;
    logic                running_n, phase_n, done_n, pass_n, fail_n;
    logic                settle, settle_n;         // a strobe was issued last cycle
    logic                ref_issued, ref_issued_n;
    logic                rd_got, rd_got_n;
    logic [TCNT_W-1:0]   tcnt, tcnt_n;
    logic [RCNT_W-1:0]   rcnt, rcnt_n;
    logic                rd_c, wr_c, refresh_c;
    logic                err_hit, step, last, complete, final_rd;
    logic                ref_pending;
    logic [7:0]          lfsr_adv;

`ifdef SDRAM_BIST_ERR_CAPTURE_EN
    logic [ADDR_W-1:0]   cap_addr_n;
    logic [7:0]          cap_exp_n, cap_got_n, err_got;
    logic                cap_valid_n;
`endif

    assign last        = &addr;
    assign ref_pending = (rcnt == '0);
    // Galois form of x^8+x^6+x^5+x^4+1
    assign lfsr_adv    = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);

    assign mem.mem_rd      = rd_c;
    assign mem.mem_wr      = wr_c;
    assign mem.mem_refresh = refresh_c;
    assign mem.mem_addr    = addr;
    assign mem.mem_din     = lfsr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            addr       <= '0;
            lfsr       <= '0;
            err_count  <= '0;
            running    <= 1'b0;
            phase      <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            settle     <= 1'b0;
            ref_issued <= 1'b0;
            rd_got     <= 1'b0;
            tcnt       <= '0;
            rcnt       <= RCNT_W'(REFRESH_PERIOD - 1);
`ifdef SDRAM_BIST_ERR_CAPTURE_EN
            first_err_addr  <= '0;
            first_err_exp   <= '0;
            first_err_got   <= '0;
            first_err_valid <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            addr       <= addr_n;
            lfsr       <= lfsr_n;
            err_count  <= err_n;
            running    <= running_n;
            phase      <= phase_n;
            done       <= done_n;
            pass       <= pass_n;
            fail       <= fail_n;
            settle     <= settle_n;
            ref_issued <= ref_issued_n;
            rd_got     <= rd_got_n;
            tcnt       <= tcnt_n;
            rcnt       <= rcnt_n;
`ifdef SDRAM_BIST_ERR_CAPTURE_EN
            first_err_addr  <= cap_addr_n;
            first_err_exp   <= cap_exp_n;
            first_err_got   <= cap_got_n;
            first_err_valid <= cap_valid_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        addr_n       = addr;
        lfsr_n       = lfsr;
        err_n        = err_count;
        running_n    = running;
        phase_n      = phase;
        done_n       = done;
        pass_n       = pass;
        fail_n       = fail;
        settle_n     = 1'b0;
        ref_issued_n = ref_issued;
        rd_got_n     = rd_got;
        tcnt_n       = tcnt;
        rcnt_n       = rcnt;
        rd_c         = 1'b0;
        wr_c         = 1'b0;
        refresh_c    = 1'b0;
        err_hit      = 1'b0;
        step         = 1'b0;
        complete     = 1'b0;
        final_rd     = 1'b0;
`ifdef SDRAM_BIST_ERR_CAPTURE_EN
        cap_addr_n   = first_err_addr;
        cap_exp_n    = first_err_exp;
        cap_got_n    = first_err_got;
        cap_valid_n  = first_err_valid;
        err_got      = 8'h00;
`endif

        if (running && !ref_pending) begin
            rcnt_n = rcnt - RCNT_W'(1);
        end

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n   = WR_ISSUE;
                    addr_n    = '0;
                    lfsr_n    = SEED;
                    err_n     = '0;
                    done_n    = 1'b0;
                    pass_n    = 1'b0;
                    fail_n    = 1'b0;
                    phase_n   = 1'b0;
                    running_n = 1'b1;
`ifdef SDRAM_BIST_ERR_CAPTURE_EN
                    cap_addr_n  = '0;
                    cap_exp_n   = '0;
                    cap_got_n   = '0;
                    cap_valid_n = 1'b0;
`endif
                end
            end
            WR_ISSUE: begin
                if (ref_pending) begin
                    state_n = REFRESH;
                end else if (!mem.mem_busy) begin
                    wr_c     = 1'b1;
                    settle_n = 1'b1;
                    state_n  = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (!settle && !mem.mem_busy) begin
                    step = 1'b1;
                    if (last) begin
                        phase_n = 1'b1;
                        state_n = RD_ISSUE;
                    end else begin
                        state_n = WR_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                if (ref_pending) begin
                    state_n = REFRESH;
                end else if (!mem.mem_busy) begin
                    rd_c     = 1'b1;
                    settle_n = 1'b1;
                    rd_got_n = 1'b0;
                    tcnt_n   = TCNT_W'(1);
                    state_n  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                complete = rd_got;
                if (!rd_got) begin
                    if (mem.mem_data_ready) begin
                        complete = 1'b1;
                        rd_got_n = 1'b1;
                        if (mem.mem_dout != lfsr) begin
                            err_hit = 1'b1;
`ifdef SDRAM_BIST_ERR_CAPTURE_EN
                            err_got = mem.mem_dout;
`endif
                        end
                    end else if (tcnt >= TCNT_W'(TIMEOUT)) begin
                        complete = 1'b1;
                        rd_got_n = 1'b1;
                        err_hit  = 1'b1;
                    end else begin
                        tcnt_n = tcnt + TCNT_W'(1);
                    end
                end
                if (complete && !settle && !mem.mem_busy) begin
                    step = 1'b1;
                    if (last) begin
                        final_rd  = 1'b1;
                        running_n = 1'b0;
                        done_n    = 1'b1;
                        state_n   = DONE;
                    end else begin
                        state_n = RD_ISSUE;
                    end
                end
            end
            REFRESH: begin
                if (!ref_issued) begin
                    if (!mem.mem_busy) begin
                        refresh_c    = 1'b1;
                        settle_n     = 1'b1;
                        ref_issued_n = 1'b1;
                    end
                end else if (!settle && !mem.mem_busy) begin
                    ref_issued_n = 1'b0;
                    rcnt_n       = RCNT_W'(REFRESH_PERIOD - 1);
                    state_n      = phase ? RD_ISSUE : WR_ISSUE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (err_hit) begin
            if (err_count != 16'hFFFF) begin
                err_n = err_count + 16'd1;
            end
`ifdef SDRAM_BIST_ERR_CAPTURE_EN
            if (!first_err_valid) begin
                cap_addr_n  = addr;
                cap_exp_n   = lfsr;
                cap_got_n   = err_got;
                cap_valid_n = 1'b1;
            end
`endif
        end

        if (step) begin
            addr_n = addr + ADDR_W'(1);
            lfsr_n = last ? SEED : lfsr_adv;
        end

        // Verdict uses the count including an error found on the final read
        if (final_rd) begin
            pass_n = (err_n == 16'd0);
            fail_n = (err_n != 16'd0);
        end
    end

endmodule
